// File: rtl/adc_sample_stats_if.sv
// Sample/control/result bundle between the ADC sample-stats block and its environment.
// master drives samples and control; slave (the stats block) drives results and status.
interface adc_sample_stats_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] SAMPLE_IN;
    logic                  SAMPLE_VALID;
    logic                  START;
    logic                  CLEAR;
    logic                  CONT;
    logic [3:0]            WINDOW_LOG2;
    logic [DATA_WIDTH-1:0] AVG_OUT;
    logic [DATA_WIDTH-1:0] MIN_OUT;
    logic [DATA_WIDTH-1:0] MAX_OUT;
    logic                  RESULT_VALID;
    logic                  BUSY;
    logic [15:0]           WIN_COUNT;

    modport master (
        output SAMPLE_IN, SAMPLE_VALID, START, CLEAR, CONT, WINDOW_LOG2,
        input  AVG_OUT, MIN_OUT, MAX_OUT, RESULT_VALID, BUSY, WIN_COUNT
    );

    modport slave (
        input  SAMPLE_IN, SAMPLE_VALID, START, CLEAR, CONT, WINDOW_LOG2,
        output AVG_OUT, MIN_OUT, MAX_OUT, RESULT_VALID, BUSY, WIN_COUNT
    );
endinterface

// File: rtl/adc_sample_stats.sv
// Windowed average/min/max over 2^N ADC samples; results registered 2 edges after the last strobe.
// No backpressure: a strobe is accepted every cycle in ACCUM, and in DONE when continuous mode re-arms.
module adc_sample_stats #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LOG2   = 10,
    parameter int ACC_WIDTH  = DATA_WIDTH + MAX_LOG2
) (
    input logic               SYSCLK,
    input logic               OPB_RST,
    adc_sample_stats_if.slave bus
);
    localparam int CNT_W = MAX_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                state, state_nxt;
    logic [ACC_WIDTH-1:0]  acc;
    logic [CNT_W-1:0]      cnt, cnt_inc, target;
    logic [DATA_WIDTH-1:0] run_min, run_max;
    logic [DATA_WIDTH-1:0] avg_q, min_q, max_q;
    logic [3:0]            n_lat, n_clamp;
    logic                  result_valid, busy;
    logic [15:0]           win_count;

    assign n_clamp = (bus.WINDOW_LOG2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : bus.WINDOW_LOG2;
    assign cnt_inc = cnt + CNT_W'(1);
    assign target  = CNT_W'(1) << n_lat;

    always_ff @(posedge SYSCLK or posedge OPB_RST) begin
        if (OPB_RST) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.CLEAR) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (bus.START) state_nxt = ACCUM;
                ACCUM: if (bus.SAMPLE_VALID && cnt_inc == target) state_nxt = DONE;
                DONE: begin
                    // With N=0 a seeding sample is already a complete window.
                    if (bus.CONT) state_nxt = (bus.SAMPLE_VALID && n_lat == 4'd0) ? DONE : ACCUM;
                    else          state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge SYSCLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            acc          <= '0;
            cnt          <= '0;
            run_min      <= '0;
            run_max      <= '0;
            avg_q        <= '0;
            min_q        <= '0;
            max_q        <= '0;
            n_lat        <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            win_count    <= '0;
        end else if (bus.CLEAR) begin
            acc          <= '0;
            cnt          <= '0;
            run_min      <= '0;
            run_max      <= '0;
            n_lat        <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            win_count    <= '0;
        end else begin
            result_valid <= 1'b0;
            busy         <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        n_lat     <= n_clamp;
                        acc       <= '0;
                        cnt       <= '0;
                        run_min   <= '1;
                        run_max   <= '0;
                        win_count <= '0;
                    end
                end
                ACCUM: begin
                    if (bus.SAMPLE_VALID) begin
                        acc <= acc + ACC_WIDTH'(bus.SAMPLE_IN);
                        cnt <= cnt_inc;
                        if (bus.SAMPLE_IN <= run_min) run_min <= bus.SAMPLE_IN;
                        if (bus.SAMPLE_IN >= run_max) run_max <= bus.SAMPLE_IN;
                    end
                end
                DONE: begin
                    avg_q        <= DATA_WIDTH'(acc >> n_lat);
                    min_q        <= run_min;
                    max_q        <= run_max;
                    result_valid <= 1'b1;
                    if (win_count != 16'hFFFF) win_count <= win_count + 16'd1;
                    if (bus.CONT) begin
                        // A strobe landing in DONE seeds the next window so nothing is lost.
                        if (bus.SAMPLE_VALID) begin
                            acc     <= ACC_WIDTH'(bus.SAMPLE_IN);
                            cnt     <= CNT_W'(1);
                            run_min <= bus.SAMPLE_IN;
                            run_max <= bus.SAMPLE_IN;
                        end else begin
                            acc     <= '0;
                            cnt     <= '0;
                            run_min <= '1;
                            run_max <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.AVG_OUT      = avg_q;
    assign bus.MIN_OUT      = min_q;
    assign bus.MAX_OUT      = max_q;
    assign bus.RESULT_VALID = result_valid;
    assign bus.BUSY         = busy;
    assign bus.WIN_COUNT    = win_count;
endmodule
